// File: rtl/vxe_mem_hub_pkg.sv
// Shared VxE memory hub definitions: request field widths and master limits.
package vxe_mem_hub_pkg;

  localparam int unsigned CID_W  = 6;
  localparam int unsigned RNW_W  = 1;
  localparam int unsigned ADDR_W = 37;
  localparam int unsigned RQ_DW  = CID_W + RNW_W + ADDR_W;
  localparam int unsigned NM_MAX = 8;

  typedef struct packed {
    logic [CID_W-1:0]  cid;
    logic [RNW_W-1:0]  rnw;
    logic [ADDR_W-1:0] addr;
  } rq_t;

endpackage

// File: rtl/vxe_mem_hub_cu_us_n_if.sv
// CU upstream request router bus: CU FIFO side plus per-master push side.
interface vxe_mem_hub_cu_us_n_if
  import vxe_mem_hub_pkg::*;
#(
  parameter int unsigned DW = RQ_DW,
  parameter int unsigned NM = 2,
  parameter int unsigned SW = 1
);

  logic [SW-1:0]    i_m_sel;
  logic             i_rqa_vld;
  logic [DW-1:0]    i_rqa;
  logic             o_rqa_rd;
  logic [NM-1:0]    i_m_rqa_rdy;
  logic [NM*DW-1:0] o_m_rqa;
  logic [NM-1:0]    o_m_rqa_wr;
  logic             o_busy;
  logic             o_sel_err;

  modport slave (
    input  i_m_sel, i_rqa_vld, i_rqa, i_m_rqa_rdy,
    output o_rqa_rd, o_m_rqa, o_m_rqa_wr, o_busy, o_sel_err
  );

  modport master (
    output i_m_sel, i_rqa_vld, i_rqa, i_m_rqa_rdy,
    input  o_rqa_rd, o_m_rqa, o_m_rqa_wr, o_busy, o_sel_err
  );

endinterface

// File: rtl/vxe_mem_hub_sfifo.sv
// Synchronous FIFO exposing head, count, push and pop; storage cleared on reset.
module vxe_mem_hub_sfifo #(
  parameter int unsigned W     = 45,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/vxe_mem_hub_cu_us_n.sv
// CU upstream request router: queues CU requests in order and pushes each to
// the master index captured at acceptance, broadcasting the head data.
module vxe_mem_hub_cu_us_n
  import vxe_mem_hub_pkg::*;
#(
  parameter int unsigned DW    = RQ_DW,
  parameter int unsigned NM    = 2,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned SW    = (NM > 1) ? $clog2(NM) : 1
) (
  input logic clk,
  input logic nrst,
  vxe_mem_hub_cu_us_n_if.slave bus
);

  localparam int unsigned EW = DW + SW;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          en_q;
  logic          sel_err_q;
  logic          accept;
  logic          sel_bad;
  logic          xfer;
  logic          busy;
  logic [SW-1:0] tgt;
  logic [SW-1:0] head_tgt;
  logic [EW-1:0] din;
  logic [EW-1:0] head;
  logic [CW-1:0] count;
  logic [NM-1:0] wr;

  // en_q holds o_rqa_rd low while reset is asserted.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      en_q      <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      en_q      <= 1'b1;
      sel_err_q <= accept && sel_bad;
    end
  end

  assign bus.o_rqa_rd = en_q && (count != CW'(DEPTH));
  assign accept       = bus.o_rqa_rd && bus.i_rqa_vld;

  // Out-of-range selects are steered to master 0.
  assign sel_bad = 32'(bus.i_m_sel) >= 32'(NM);
  assign tgt     = sel_bad ? '0 : bus.i_m_sel;
  assign din     = {tgt, bus.i_rqa};

  vxe_mem_hub_sfifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_q (
    .clk   (clk),
    .nrst  (nrst),
    .push  (accept),
    .din   (din),
    .pop   (xfer),
    .head  (head),
    .count (count)
  );

  assign busy     = (count != '0);
  assign head_tgt = head[EW-1:DW];

  always_comb begin
    wr = '0;
    for (int k = 0; k < int'(NM); k++) begin
      wr[k] = busy && (head_tgt == SW'(k));
    end
  end

  assign xfer = |(wr & bus.i_m_rqa_rdy);

  assign bus.o_m_rqa_wr = wr;
  assign bus.o_m_rqa    = {NM{head[DW-1:0]}};
  assign bus.o_busy     = busy;
  assign bus.o_sel_err  = sel_err_q;

endmodule

// File: tb/tb_vxe_mem_hub_cu_us_n.sv
// Directed bench for the CU upstream router: three configurations on one clock.
module tb_vxe_mem_hub_cu_us_n;

  logic clk;
  logic nrst;
  int   vec;
  int   errs;

  vxe_mem_hub_cu_us_n_if #(.DW(44), .NM(2), .SW(1)) b2 ();
  vxe_mem_hub_cu_us_n_if #(.DW(44), .NM(4), .SW(2)) b4 ();
  vxe_mem_hub_cu_us_n_if #(.DW(44), .NM(3), .SW(2)) b3 ();

  vxe_mem_hub_cu_us_n #(.DW(44), .NM(2), .DEPTH(2), .SW(1)) d2 (
    .clk (clk), .nrst (nrst), .bus (b2));
  vxe_mem_hub_cu_us_n #(.DW(44), .NM(4), .DEPTH(4), .SW(2)) d4 (
    .clk (clk), .nrst (nrst), .bus (b4));
  vxe_mem_hub_cu_us_n #(.DW(44), .NM(3), .DEPTH(2), .SW(2)) d3 (
    .clk (clk), .nrst (nrst), .bus (b3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    clk  = 1'b0;
    nrst = 1'b0;
    b2.i_m_sel = '0; b2.i_rqa_vld = 1'b0; b2.i_rqa = '0; b2.i_m_rqa_rdy = '0;
    b4.i_m_sel = '0; b4.i_rqa_vld = 1'b0; b4.i_rqa = '0; b4.i_m_rqa_rdy = '0;
    b3.i_m_sel = '0; b3.i_rqa_vld = 1'b0; b3.i_rqa = '0; b3.i_m_rqa_rdy = '0;

    // Reset values.
    #2;
    chk("rst_rd",      64'(b2.o_rqa_rd),   64'(0));
    chk("rst_wr",      64'(b2.o_m_rqa_wr), 64'(0));
    chk("rst_data",    64'(b2.o_m_rqa[43:0]), 64'(0));
    chk("rst_busy",    64'(b2.o_busy),     64'(0));
    chk("rst_selerr",  64'(b2.o_sel_err),  64'(0));
    chk("rst_rd_nm4",  64'(b4.o_rqa_rd),   64'(0));
    step();
    step();
    nrst = 1'b1;

    // First cycle after release, then idle with vld low.
    step();
    chk("rel_rd", 64'(b2.o_rqa_rd), 64'(1));
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_rd",   64'(b2.o_rqa_rd),   64'(1));
      chk("idle_wr",   64'(b2.o_m_rqa_wr), 64'(0));
      chk("idle_busy", 64'(b2.o_busy),     64'(0));
    end

    // Streaming on NM=4 to master 2.
    b4.i_m_sel     = 2'd2;
    b4.i_m_rqa_rdy = 4'hF;
    b4.i_rqa_vld   = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      b4.i_rqa = 44'(i);
      step();
      chk("stream_wr",    64'(b4.o_m_rqa_wr),      64'(4'b0100));
      chk("stream_data2", 64'(b4.o_m_rqa[88 +: 44]), 64'(i));
      chk("stream_data0", 64'(b4.o_m_rqa[0 +: 44]),  64'(i));
    end
    b4.i_rqa_vld = 1'b0;
    step();
    chk("stream_end_wr",   64'(b4.o_m_rqa_wr), 64'(0));
    chk("stream_end_busy", 64'(b4.o_busy),     64'(0));

    // Backpressure on NM=2, DEPTH=2, master 1 not ready.
    b2.i_m_sel     = 1'b1;
    b2.i_m_rqa_rdy = 2'b01;
    b2.i_rqa_vld   = 1'b1;
    b2.i_rqa       = 44'h0A1;
    step();
    chk("bp_wr1",   64'(b2.o_m_rqa_wr),      64'(2'b10));
    chk("bp_data1", 64'(b2.o_m_rqa[44 +: 44]), 64'(44'h0A1));
    chk("bp_rd1",   64'(b2.o_rqa_rd),        64'(1));
    b2.i_rqa = 44'h0A2;
    step();
    chk("bp_full_rd",   64'(b2.o_rqa_rd),        64'(0));
    chk("bp_full_busy", 64'(b2.o_busy),          64'(1));
    chk("bp_full_data", 64'(b2.o_m_rqa[44 +: 44]), 64'(44'h0A1));
    b2.i_rqa = 44'h0A3;
    step();
    chk("bp_hold_rd",   64'(b2.o_rqa_rd),        64'(0));
    chk("bp_hold_wr",   64'(b2.o_m_rqa_wr),      64'(2'b10));
    chk("bp_hold_data", 64'(b2.o_m_rqa[44 +: 44]), 64'(44'h0A1));
    b2.i_m_rqa_rdy = 2'b11;
    b2.i_rqa_vld   = 1'b0;
    step();
    chk("bp_rel_wr",   64'(b2.o_m_rqa_wr),      64'(2'b10));
    chk("bp_rel_data", 64'(b2.o_m_rqa[44 +: 44]), 64'(44'h0A2));
    chk("bp_rel_rd",   64'(b2.o_rqa_rd),        64'(1));
    step();
    chk("bp_done_wr",   64'(b2.o_m_rqa_wr), 64'(0));
    chk("bp_done_busy", 64'(b2.o_busy),     64'(0));

    // Select switch: A to master 0 (stalled), B to master 1 behind it.
    b2.i_m_rqa_rdy = 2'b10;
    b2.i_m_sel     = 1'b0;
    b2.i_rqa_vld   = 1'b1;
    b2.i_rqa       = 44'h0AA;
    step();
    chk("sw_a_wr",   64'(b2.o_m_rqa_wr),     64'(2'b01));
    chk("sw_a_data", 64'(b2.o_m_rqa[0 +: 44]), 64'(44'h0AA));
    b2.i_m_sel = 1'b1;
    b2.i_rqa   = 44'h0BB;
    step();
    chk("sw_b_wait_wr",   64'(b2.o_m_rqa_wr),     64'(2'b01));
    chk("sw_b_wait_data", 64'(b2.o_m_rqa[0 +: 44]), 64'(44'h0AA));
    b2.i_rqa_vld = 1'b0;
    step();
    chk("sw_stall_wr", 64'(b2.o_m_rqa_wr), 64'(2'b01));
    b2.i_m_rqa_rdy = 2'b11;
    step();
    chk("sw_b_wr",   64'(b2.o_m_rqa_wr),      64'(2'b10));
    chk("sw_b_data", 64'(b2.o_m_rqa[44 +: 44]), 64'(44'h0BB));
    step();
    chk("sw_done_wr",   64'(b2.o_m_rqa_wr), 64'(0));
    chk("sw_done_busy", 64'(b2.o_busy),     64'(0));

    // Bad select on NM=3.
    b3.i_m_rqa_rdy = 3'b111;
    b3.i_m_sel     = 2'd3;
    b3.i_rqa_vld   = 1'b1;
    b3.i_rqa       = 44'h0C0;
    chk("bad_pre_err", 64'(b3.o_sel_err), 64'(0));
    step();
    chk("bad_err",  64'(b3.o_sel_err),        64'(1));
    chk("bad_wr",   64'(b3.o_m_rqa_wr),       64'(3'b001));
    chk("bad_data", 64'(b3.o_m_rqa[0 +: 44]), 64'(44'h0C0));
    b3.i_m_sel = 2'd2;
    b3.i_rqa   = 44'h0D0;
    step();
    chk("bad_err_clr", 64'(b3.o_sel_err),         64'(0));
    chk("good_wr",     64'(b3.o_m_rqa_wr),        64'(3'b100));
    chk("good_data",   64'(b3.o_m_rqa[88 +: 44]), 64'(44'h0D0));
    b3.i_rqa_vld = 1'b0;
    step();
    chk("good_err", 64'(b3.o_sel_err),  64'(0));
    chk("good_end", 64'(b3.o_m_rqa_wr), 64'(0));

    // Mid-operation reset with a full queue.
    b2.i_m_rqa_rdy = 2'b00;
    b2.i_m_sel     = 1'b1;
    b2.i_rqa_vld   = 1'b1;
    b2.i_rqa       = 44'h0E1;
    step();
    b2.i_rqa = 44'h0E2;
    step();
    chk("mr_full_rd",   64'(b2.o_rqa_rd), 64'(0));
    chk("mr_full_busy", 64'(b2.o_busy),   64'(1));
    b2.i_rqa_vld = 1'b0;
    nrst = 1'b0;
    #1;
    chk("mr_rst_rd",   64'(b2.o_rqa_rd),      64'(0));
    chk("mr_rst_wr",   64'(b2.o_m_rqa_wr),    64'(0));
    chk("mr_rst_data", 64'(b2.o_m_rqa),       64'(0));
    chk("mr_rst_busy", 64'(b2.o_busy),        64'(0));
    step();
    nrst = 1'b1;
    b2.i_m_rqa_rdy = 2'b11;
    step();
    chk("mr_rel_rd",   64'(b2.o_rqa_rd),   64'(1));
    chk("mr_rel_busy", 64'(b2.o_busy),     64'(0));
    chk("mr_rel_wr",   64'(b2.o_m_rqa_wr), 64'(0));
    step();
    chk("mr_stale_wr", 64'(b2.o_m_rqa_wr), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
